// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and bus layouts for the memory stage.
// Bus structs mirror the bit fields exchanged with execute, write-back and decode.
// Load-type and wait-state encodings live here so sub-modules agree on them.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 75;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_FWD_WD = 39;

    // Codes 5..7 are not assigned and fall through to word behaviour.
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic        mem_req;
        logic [2:0]  load_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_valid;
        logic        fwd_stall;
        logic [4:0]  dest;
        logic [31:0] value;
    } ms_to_ds_fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Purpose: select the addressed byte/halfword of a load and sign/zero extend it.
// Latency: purely combinational; no backpressure involvement.
// Ports: load_type, addr (low two address bits), rdata in; result out.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (load_type)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Purpose: MIPS memory stage; holds one instruction until its data-SRAM response, aligns load data.
// Latency: 1 cycle for non-memory ops; memory ops leave in the data_ok cycle or later.
// Backpressure: ms_allowin low while occupied and not leaving; late responses buffered in rdata_buf.
// Ports: clk/resetn; es_to_ms_valid/bus in, ms_allowin out; ms_to_ws_valid/bus out, ws_allowin in;
//        data_sram_data_ok/rdata in; ms_to_ds_fwd out to decode; ms_valid out.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_valid
);

    es_to_ms_t      es_to_ms_bus_r;
    ms_state_e      state;
    ms_state_e      state_nxt;
    logic [31:0]    rdata_buf;
    logic           data_ok_eff;
    logic           ms_ready_go;
    logic           accept;
    logic           leave;
    logic [31:0]    raw_rdata;
    logic [31:0]    aligned_load;
    logic [31:0]    final_result;
    ms_to_ws_t      ws_out;
    ms_to_ds_fwd_t  fwd_out;

    // A response only counts for an instruction that is actually waiting on it;
    // anything else (idle, post-reset, already-ready) is a stray and is dropped.
    assign data_ok_eff    = ms_valid && (state == ST_WAIT) && data_sram_data_ok;
    assign ms_ready_go    = (state == ST_READY) || data_ok_eff;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept         = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign leave          = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept wins over leave: in a leave+accept cycle the new instruction's
    // own mem_req decides where it starts.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = es_to_ms_bus[ES_TO_MS_BUS_WD-1] ? ST_WAIT : ST_READY;
        end else if (leave) begin
            state_nxt = ST_EMPTY;
        end else if (data_ok_eff) begin
            state_nxt = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            es_to_ms_bus_r <= '0;
            rdata_buf      <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                es_to_ms_bus_r <= es_to_ms_bus;
            end
            // Buffer only when the response cannot be handed on this cycle.
            if (data_ok_eff && !ws_allowin) begin
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign raw_rdata = data_ok_eff ? data_sram_rdata : rdata_buf;

    load_align u_load_align (
        .load_type (es_to_ms_bus_r.load_type),
        .addr      (es_to_ms_bus_r.alu_result[1:0]),
        .rdata     (raw_rdata),
        .result    (aligned_load)
    );

    assign final_result = es_to_ms_bus_r.res_from_mem ? aligned_load : es_to_ms_bus_r.alu_result;

    always_comb begin
        ws_out.gr_we        = es_to_ms_bus_r.gr_we;
        ws_out.dest         = es_to_ms_bus_r.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = es_to_ms_bus_r.pc;

        fwd_out.fwd_valid   = ms_valid && es_to_ms_bus_r.gr_we && (es_to_ms_bus_r.dest != 5'd0);
        fwd_out.fwd_stall   = fwd_out.fwd_valid && es_to_ms_bus_r.res_from_mem && !ms_ready_go;
        fwd_out.dest        = es_to_ms_bus_r.dest;
        fwd_out.value       = final_result;
    end

    assign ms_to_ws_bus = ws_out;
    assign ms_to_ds_fwd = fwd_out;

endmodule
